// File: rtl/sram_access_ctrl.sv
// Sequencer between the SLC-3 MAR/MDR side and a 16-bit asynchronous SRAM.
// Every strobe, the address and the I_O drive enable are registered from the next state.
module sram_access_ctrl #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] A,
    inout  wire  [15:0] I_O,
    output logic [2:0]  state_dbg
);

    // Handshake: a request is taken on the edge where req_valid && req_ready;
    // req_ready is high only in ST_IDLE and req_valid is never queued.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_SETUP = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    be_q;
    logic [15:0]   wdata_q;
    logic          drive_q;
    logic          accept;
    logic [1:0]    cur_be;
    logic          ce_d, ub_d, lb_d, oe_d, we_d, drive_d, rsp_valid_d;

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;
    assign I_O       = drive_q ? wdata_q : 16'hzzzz;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_be == 2'b00) state_d = ST_DONE;
                    else if (req_we)     state_d = ST_WR_SETUP;
                    else                 state_d = ST_RD_SETUP;
                end
            end
            ST_RD_SETUP: state_d = ST_RD_WAIT;
            ST_RD_WAIT:  if (cnt_q == '0) state_d = ST_DONE;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: if (cnt_q == '0) state_d = ST_WR_HOLD;
            ST_WR_HOLD:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered, so the flops below
    // present them in the same cycle the FSM is in that state.
    always_comb begin
        cur_be      = (state_q == ST_IDLE) ? req_be : be_q;
        ce_d        = 1'b1;
        oe_d        = 1'b1;
        we_d        = 1'b1;
        ub_d        = 1'b1;
        lb_d        = 1'b1;
        drive_d     = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_d)
            ST_RD_SETUP, ST_RD_WAIT: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                ub_d = ~cur_be[1];
                lb_d = ~cur_be[0];
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_d    = 1'b0;
                ub_d    = ~cur_be[1];
                lb_d    = ~cur_be[0];
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_d    = 1'b0;
                we_d    = 1'b0;
                ub_d    = ~cur_be[1];
                lb_d    = ~cur_be[0];
                drive_d = 1'b1;
            end
            ST_DONE: rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            CE        <= 1'b1;
            UB        <= 1'b1;
            LB        <= 1'b1;
            OE        <= 1'b1;
            WE        <= 1'b1;
            A         <= '0;
            drive_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            CE        <= ce_d;
            UB        <= ub_d;
            LB        <= lb_d;
            OE        <= oe_d;
            WE        <= we_d;
            drive_q   <= drive_d;
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                A       <= req_addr;
                be_q    <= req_be;
                wdata_q <= req_wdata;
            end
            case (state_q)
                ST_RD_SETUP: cnt_q <= CW'(RD_WAIT - 1);
                ST_WR_SETUP: cnt_q <= CW'(WR_WAIT - 1);
                ST_RD_WAIT, ST_WR_PULSE: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
            if (state_q == ST_RD_WAIT && cnt_q == '0)
                rsp_rdata <= {be_q[1] ? I_O[15:8] : 8'h00, be_q[0] ? I_O[7:0] : 8'h00};
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: instance a uses default waits, instance b uses RD_WAIT=3/WR_WAIT=2.
// Each instance talks to its own behavioural SRAM; sel picks which one the driver tasks use.
module tb_sram_access_ctrl;

    localparam int B_RD = 3;
    localparam int B_WR = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        sel = 1'b0;
    logic        chk_en = 1'b0;

    logic        ready_a, rsp_valid_a, busy_a, ce_a, ub_a, lb_a, oe_a, we_a;
    logic        ready_b, rsp_valid_b, busy_b, ce_b, ub_b, lb_b, oe_b, we_b;
    logic [15:0] rdata_a, rdata_b;
    logic [19:0] a_a, a_b;
    logic [2:0]  state_a, state_b;
    wire  [15:0] io_a, io_b;

    sram_access_ctrl u_a (
        .Clk(Clk), .Reset(Reset), .req_valid(valid_a), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .busy(busy_a),
        .CE(ce_a), .UB(ub_a), .LB(lb_a), .OE(oe_a), .WE(we_a), .A(a_a), .I_O(io_a),
        .state_dbg(state_a)
    );

    sram_access_ctrl #(.RD_WAIT(B_RD), .WR_WAIT(B_WR)) u_b (
        .Clk(Clk), .Reset(Reset), .req_valid(valid_b), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .busy(busy_b),
        .CE(ce_b), .UB(ub_b), .LB(lb_b), .OE(oe_b), .WE(we_b), .A(a_b), .I_O(io_b),
        .state_dbg(state_b)
    );

    // Behavioural SRAMs: drive the whole word on reads, store enabled bytes while WE is low.
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    assign io_a = (!ce_a && !oe_a) ? mem_a[a_a[7:0]] : 16'hzzzz;
    assign io_b = (!ce_b && !oe_b) ? mem_b[a_b[7:0]] : 16'hzzzz;

    always @(posedge Clk) begin
        if (!ce_a && !we_a) begin
            if (!ub_a) mem_a[a_a[7:0]][15:8] <= io_a[15:8];
            if (!lb_a) mem_a[a_a[7:0]][7:0]  <= io_a[7:0];
        end
        if (!ce_b && !we_b) begin
            if (!ub_b) mem_b[a_b[7:0]][15:8] <= io_b[15:8];
            if (!lb_b) mem_b[a_b[7:0]][7:0]  <= io_b[7:0];
        end
    end

    logic        m_ready, m_rsp_valid, m_ce, m_ub, m_lb;
    logic [15:0] m_rdata;
    assign m_ready     = sel ? ready_b     : ready_a;
    assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_ce        = sel ? ce_b        : ce_a;
    assign m_ub        = sel ? ub_b        : ub_a;
    assign m_lb        = sel ? lb_b        : lb_a;
    assign m_rdata     = sel ? rdata_b     : rdata_a;

    int n_vec = 0;
    int n_miss = 0;
    int rsp_cnt_b = 0;
    int acc_b = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_b [32];
    logic [15:0] last_b = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An undriven net reads as z in a 4-state simulator and as 0 in a 2-state one.
    function automatic logic is_float(input logic [15:0] v);
        return $isunknown(v) ? (v === 16'hzzzz) : (v == 16'h0000);
    endfunction

    // Protocol checker on both instances.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("oe_we_overlap_a", 32'(!oe_a && !we_a), 32'd0);
            check("oe_we_overlap_b", 32'(!oe_b && !we_b), 32'd0);
            if (ce_a) check("io_float_a", 32'(is_float(io_a)), 32'd1);
            if (ce_b) check("io_float_b", 32'(is_float(io_b)), 32'd1);
            if (rsp_valid_b) rsp_cnt_b++;
        end
    end

    task automatic run_txn(input logic we, input logic [19:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, output int lat, output logic [15:0] rdata,
                           output logic ce_seen, output logic strobe_err);
        int waited;
        waited = 0;
        lat = 0;
        rdata = '0;
        ce_seen = 1'b0;
        strobe_err = 1'b0;
        @(negedge Clk);
        while (!m_ready && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        if (!m_ready) begin
            check("req_ready_timeout", 32'(m_ready), 32'd1);
            return;
        end
        req_we = we;
        req_addr = addr;
        req_wdata = wdata;
        req_be = be;
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        @(posedge Clk);
        if (sel) acc_b++;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
            if (!m_ce) begin
                ce_seen = 1'b1;
                if (m_ub !== ~be[1] || m_lb !== ~be[0] || m_rsp_valid) strobe_err = 1'b1;
            end
            if (m_rsp_valid) begin
                lat = n;
                rdata = m_rdata;
                break;
            end
        end
    endtask

    // Scoreboarded transaction on instance b against model_b.
    task automatic sb_txn(input logic we, input logic [4:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be);
        int lat, exp_lat;
        logic [15:0] rdata, exp_rd;
        logic ce_seen, serr;
        if (be == 2'b00) exp_lat = 1;
        else if (we)     exp_lat = 3 + B_WR;
        else             exp_lat = 2 + B_RD;
        exp_rd = last_b;
        if (!we && be != 2'b00)
            exp_rd = {be[1] ? model_b[addr][15:8] : 8'h00, be[0] ? model_b[addr][7:0] : 8'h00};
        exp_q.push_back(exp_rd);
        run_txn(we, 20'(addr), wdata, be, lat, rdata, ce_seen, serr);
        check("rand_latency", 32'(lat), 32'(exp_lat));
        check("rand_rdata", 32'(rdata), 32'(exp_q.pop_front()));
        check("rand_ce_use", 32'(ce_seen), 32'(be != 2'b00));
        check("rand_strobes", 32'(serr), 32'd0);
        last_b = exp_rd;
        if (we) begin
            if (be[1]) model_b[addr][15:8] = wdata[15:8];
            if (be[0]) model_b[addr][7:0]  = wdata[7:0];
        end
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, rsp_seen;
        logic [15:0] rdata;
        logic ce_seen, serr;

        vecs[0] = '{1'b1, 20'h00005, 16'hBEEF, 2'b11, 4, 16'h0000};
        vecs[1] = '{1'b0, 20'h00005, 16'h0000, 2'b11, 3, 16'hBEEF};
        vecs[2] = '{1'b1, 20'h00005, 16'h12AA, 2'b10, 4, 16'hBEEF};
        vecs[3] = '{1'b0, 20'h00005, 16'h0000, 2'b11, 3, 16'h12EF};
        vecs[4] = '{1'b0, 20'h00005, 16'h0000, 2'b01, 3, 16'h00EF};
        vecs[5] = '{1'b0, 20'h00005, 16'h0000, 2'b00, 1, 16'h00EF};
        vecs[6] = '{1'b1, 20'h00006, 16'h5A5A, 2'b11, 4, 16'h00EF};
        vecs[7] = '{1'b1, 20'h00006, 16'h1234, 2'b00, 1, 16'h00EF};
        vecs[8] = '{1'b0, 20'h00006, 16'h0000, 2'b11, 3, 16'h5A5A};

        // Reset values while Reset is held.
        repeat (2) @(negedge Clk);
        chk_en = 1'b1;
        check("rst_strobes_a", 32'({ce_a, ub_a, lb_a, oe_a, we_a}), 32'h1f);
        check("rst_strobes_b", 32'({ce_b, ub_b, lb_b, oe_b, we_b}), 32'h1f);
        check("rst_addr", 32'(a_a), 32'd0);
        check("rst_rsp", 32'({rsp_valid_a, busy_a, ready_a}), 32'b001);
        check("rst_rdata", 32'(rdata_a), 32'd0);
        check("rst_io_float", 32'(is_float(io_a)), 32'd1);
        Reset = 1'b0;

        // Directed vectors on instance a.
        sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rdata, ce_seen, serr);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
            check($sformatf("vec%0d_ce_use", i), 32'(ce_seen), 32'(vecs[i].be != 2'b00));
            check($sformatf("vec%0d_strobes", i), 32'(serr), 32'd0);
        end

        // Reset asserted in the middle of a write pulse.
        @(negedge Clk);
        req_we = 1'b1;
        req_addr = 20'h00007;
        req_wdata = 16'hC3C3;
        req_be = 2'b11;
        valid_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        valid_a = 1'b0;
        @(negedge Clk);
        check("t5_we_low", 32'(we_a), 32'd0);
        Reset = 1'b1;
        #1;
        check("t5_strobes_idle", 32'({we_a, ce_a, oe_a}), 32'b111);
        check("t5_io_float", 32'(is_float(io_a)), 32'd1);
        check("t5_ready", 32'(ready_a), 32'd1);
        @(negedge Clk);
        Reset = 1'b0;
        rsp_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge Clk);
            if (rsp_valid_a) rsp_seen++;
        end
        check("t5_no_rsp", 32'(rsp_seen), 32'd0);

        // Preload then random traffic on instance b.
        sel = 1'b1;
        for (int i = 0; i < 32; i++)
            sb_txn(1'b1, 5'(i), {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))}, 2'b11);
        for (int i = 0; i < 80; i++)
            sb_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))},
                   2'($urandom_range(0, 3)));
        repeat (3) @(negedge Clk);
        check("rsp_per_accept", 32'(rsp_cnt_b), 32'(acc_b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
